// File: rtl/fir_decim_requant.sv
// Decimate the Q30 FIR accumulator, round and saturate it to Q15, and queue
// the results in a first-word fall-through FIFO with a valid/ready output.
module fir_decim_requant #(
    parameter int DECIM      = 2,
    parameter int SHIFT      = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic signed [31:0]                    din,
    input  logic                                  din_valid,
    output logic signed [15:0]                    dout,
    output logic                                  dout_valid,
    input  logic                                  dout_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_level,
    output logic                                  sat_event,
    output logic                                  overflow_sticky
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0]     PHASE_LAST = PW'(DECIM - 1);
    localparam logic signed [32:0] ROUND     = 33'sd1 <<< (SHIFT - 1);

    logic [PW-1:0]       phase_q, phase_d;
    logic signed [15:0]  s1_data_q, s1_data_d;
    logic                s1_valid_q, s1_valid_d;
    logic                sat_q, sat_d;
    logic signed [15:0]  mem_q [FIFO_DEPTH];
    logic signed [15:0]  mem_d [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       count_q, count_d;
    logic                ovf_q, ovf_d;

    logic                keep;
    logic signed [32:0]  din_ext, rounded, shifted;
    logic                clip_hi, clip_lo;
    logic                full, pop, push_ok;

    // Stage 1: decimation phase plus round-half-up and saturation.
    always_comb begin
        keep    = din_valid && (phase_q == '0);
        phase_d = phase_q;
        if (din_valid) begin
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
        end
        din_ext   = {din[31], din};
        rounded   = din_ext + ROUND;
        shifted   = rounded >>> SHIFT;
        clip_hi   = shifted > 33'sd32767;
        clip_lo   = shifted < -33'sd32768;
        s1_data_d = s1_data_q;
        if (keep) begin
            s1_data_d = clip_hi ? 16'sh7FFF : (clip_lo ? 16'sh8000 : shifted[15:0]);
        end
        s1_valid_d = keep;
        sat_d      = keep && (clip_hi || clip_lo);
    end

    // Stage 2: a push into a full FIFO still succeeds when the head leaves the same cycle.
    always_comb begin
        full     = (count_q == LW'(FIFO_DEPTH));
        pop      = dout_valid && dout_ready;
        push_ok  = s1_valid_q && (!full || pop);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = s1_data_q;
        end
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + LW'(push_ok) - LW'(pop);
        ovf_d    = ovf_q || (s1_valid_q && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            sat_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            phase_q    <= phase_d;
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
            sat_q      <= sat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            mem_q      <= mem_d;
        end
    end

    assign dout_valid      = (count_q != '0);
    assign dout            = dout_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level      = count_q;
    assign sat_event       = sat_q;
    assign overflow_sticky = ovf_q;

endmodule

// File: tb/tb_fir_decim_requant.sv
// Bench for fir_decim_requant: vector table for requantisation plus
// hand-written decimation, backpressure, full+pop and reset sequences.
module tb_fir_decim_requant;

    localparam logic [31:0] JUNK = 32'h7FFF_FFFF;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [31:0] din = '0;
    logic               din_valid = 1'b0;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               dout_ready = 1'b0;
    logic [2:0]         fifo_level;
    logic               sat_event;
    logic               overflow_sticky;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int sb[$];

    typedef struct {
        logic [31:0] din;
        int          exp_dout;
        logic        exp_sat;
    } vec_t;
    vec_t vecs[10];

    fir_decim_requant dut (
        .clk             (clk),
        .rst             (rst),
        .din             (din),
        .din_valid       (din_valid),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .fifo_level      (fifo_level),
        .sat_event       (sat_event),
        .overflow_sticky (overflow_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: actual %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic [31:0] d, input logic v);
        @(posedge clk);
        #1;
        din       = d;
        din_valid = v;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check(name, sb.size(), 0);
    endtask

    // Scoreboard: handshake seen before the edge, so compare the head now.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            if (sb.size() == 0) check("sb_unexpected_dout", sb.size(), 1);
            else check("sb_dout", dout, sb.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_4000,      1, 1'b0};
        vecs[1] = '{32'h0000_3FFF,      0, 1'b0};
        vecs[2] = '{32'hFFFF_C000,      0, 1'b0};
        vecs[3] = '{32'hFFFF_BFFF,     -1, 1'b0};
        vecs[4] = '{32'h4000_0000,  32767, 1'b1};
        vecs[5] = '{32'h8000_0000, -32768, 1'b1};
        vecs[6] = '{32'h3FFF_8000,  32767, 1'b0};
        vecs[7] = '{32'h3FFF_C000,  32767, 1'b1};
        vecs[8] = '{32'hC000_0000, -32768, 1'b0};
        vecs[9] = '{32'hBFFF_BFFF, -32768, 1'b1};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_sat", sat_event, 0);
        check("rst_sticky", overflow_sticky, 0);

        // Requantisation table: each vector is kept, followed by a discarded sample.
        dout_ready = 1'b1;
        foreach (vecs[i]) begin
            sb.push_back(vecs[i].exp_dout);
            drive(vecs[i].din, 1'b1);
            drive(JUNK, 1'b1);
            @(negedge clk);
            check($sformatf("vec%0d_sat", i), sat_event, vecs[i].exp_sat);
            drive(32'h0, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d_sat_clear", i), sat_event, 0);
        end
        wait_drain("table_drain");

        // Decimation with continuous valid input.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            if (k % 2 == 1) sb.push_back(k);
            drive(32'(k) << 15, 1'b1);
            @(negedge clk);
            if (k == 2) check("first_valid_early", dout_valid, 0);
            if (k == 3) check("first_valid_on_time", dout_valid, 1);
        end
        drive(32'h0, 1'b0);
        wait_drain("decim_drain");

        // Backpressure: fifth kept sample hits a full FIFO.
        dout_ready = 1'b0;
        do_reset();
        for (int k = 10; k <= 14; k++) begin
            if (k < 14) sb.push_back(k);
            drive(32'(k) << 15, 1'b1);
            drive(JUNK, 1'b1);
        end
        drive(32'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_level", fifo_level, 4);
        check("bp_sticky", overflow_sticky, 1);
        check("bp_head", dout, 10);
        @(negedge clk);
        check("bp_head_stable", dout, 10);
        dout_ready = 1'b1;
        wait_drain("bp_drain");
        @(negedge clk);
        check("bp_empty_level", fifo_level, 0);
        check("bp_empty_dout", dout, 0);
        check("bp_empty_valid", dout_valid, 0);
        check("bp_sticky_held", overflow_sticky, 1);
        dout_ready = 1'b0;
        do_reset();
        @(negedge clk);
        check("bp_sticky_cleared", overflow_sticky, 0);

        // Full FIFO with push and pop on the same edge.
        for (int k = 20; k <= 23; k++) begin
            sb.push_back(k);
            drive(32'(k) << 15, 1'b1);
            drive(JUNK, 1'b1);
        end
        sb.push_back(24);
        drive(32'(24) << 15, 1'b1);
        drive(JUNK, 1'b1);
        dout_ready = 1'b1;
        drive(32'h0, 1'b0);
        dout_ready = 1'b0;
        @(negedge clk);
        check("fullpop_level", fifo_level, 4);
        check("fullpop_sticky", overflow_sticky, 0);
        dout_ready = 1'b1;
        wait_drain("fullpop_drain");
        dout_ready = 1'b0;

        // Reset mid-stream with level 3 and phase 1.
        do_reset();
        for (int k = 30; k <= 32; k++) begin
            sb.push_back(k);
            drive(32'(k) << 15, 1'b1);
            if (k < 32) drive(JUNK, 1'b1);
        end
        drive(32'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_level_before", fifo_level, 3);
        do_reset();
        sb.delete();
        @(negedge clk);
        check("mid_valid", dout_valid, 0);
        check("mid_level", fifo_level, 0);
        check("mid_sticky", overflow_sticky, 0);
        check("mid_dout", dout, 0);
        dout_ready = 1'b1;
        sb.push_back(5);
        drive(32'(5) << 15, 1'b1);
        drive(32'h0, 1'b0);
        wait_drain("mid_restart_drain");
        dout_ready = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
